// File: rtl/arcade_input_pkg.sv
// Shared constants, enums and the PS/2 scancode decoder for arcade_input_mapper.
// Scancodes are PS/2 set 2. The extended prefix is not part of the lookup.
package arcade_input_pkg;

    localparam int unsigned PC_UP    = 0;
    localparam int unsigned PC_DOWN  = 1;
    localparam int unsigned PC_LEFT  = 2;
    localparam int unsigned PC_RIGHT = 3;
    localparam int unsigned PC_FIRE  = 4;
    localparam int unsigned PC_BOMB  = 5;
    localparam int unsigned PC_START = 6;
    localparam int unsigned PC_COIN  = 7;

    localparam int unsigned JS_RIGHT  = 0;
    localparam int unsigned JS_LEFT   = 1;
    localparam int unsigned JS_DOWN   = 2;
    localparam int unsigned JS_UP     = 3;
    localparam int unsigned JS_FIRE   = 4;
    localparam int unsigned JS_BOMB   = 5;
    localparam int unsigned JS_START  = 6;
    localparam int unsigned JS_START2 = 7;
    localparam int unsigned JS_COIN   = 8;

    typedef enum logic [1:0] {
        ROT_NONE  = 2'd0,
        ROT_LEFT  = 2'd1,
        ROT_RIGHT = 2'd2,
        ROT_180   = 2'd3
    } rotate_t;

    typedef enum logic [1:0] {
        CoinIdle = 2'd0,
        CoinHold = 2'd1,
        CoinGap  = 2'd2
    } coin_state_e;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_6     = 8'h36;

    // Key-state slots 0..7 follow p_ctrl bit order; slot 8 is the alternate start key.
    localparam int unsigned KS_START_ALT = 8;

    typedef struct packed {
        logic       hit;
        logic       player;
        logic [3:0] slot;
    } key_slot_t;

    function automatic key_slot_t sc_decode(input logic [7:0] sc);
        key_slot_t s;
        s.hit    = 1'b1;
        s.player = 1'b0;
        s.slot   = 4'd0;
        case (sc)
            SC_UP:    s.slot = 4'd0;
            SC_DOWN:  s.slot = 4'd1;
            SC_LEFT:  s.slot = 4'd2;
            SC_RIGHT: s.slot = 4'd3;
            SC_SPACE: s.slot = 4'd4;
            SC_CTRL:  s.slot = 4'd5;
            SC_1:     s.slot = 4'd6;
            SC_5:     s.slot = 4'd7;
            SC_F1:    s.slot = 4'd8;
            SC_R:     begin s.player = 1'b1; s.slot = 4'd0; end
            SC_F:     begin s.player = 1'b1; s.slot = 4'd1; end
            SC_D:     begin s.player = 1'b1; s.slot = 4'd2; end
            SC_G:     begin s.player = 1'b1; s.slot = 4'd3; end
            SC_A:     begin s.player = 1'b1; s.slot = 4'd4; end
            SC_S:     begin s.player = 1'b1; s.slot = 4'd5; end
            SC_2:     begin s.player = 1'b1; s.slot = 4'd6; end
            SC_6:     begin s.player = 1'b1; s.slot = 4'd7; end
            SC_F2:    begin s.player = 1'b1; s.slot = 4'd8; end
            default:  s.hit = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/arcade_coin_stretch.sv
// One coin channel: rising-edge detect, IDLE/HOLD/GAP FSM and a shared down-counter.
// Edges arriving outside IDLE are dropped, so a held coin never retriggers.
module arcade_coin_stretch
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_HOLD = 1_800_000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic armed,
    input  logic coin_raw,
    output logic coin
);

    localparam int unsigned CntW = (COIN_HOLD > 1) ? $clog2(COIN_HOLD) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(COIN_HOLD - 1);

    coin_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            prev_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CoinIdle;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= coin_raw;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CoinIdle: begin
                // No trigger on the arm cycle: a coin held through reset is not an edge.
                if (armed && coin_raw && !prev_q) begin
                    state_d = CoinHold;
                    cnt_d   = CntLoad;
                end
            end
            CoinHold: begin
                if (cnt_q == '0) begin
                    state_d = CoinGap;
                    cnt_d   = CntLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            CoinGap: begin
                if (cnt_q == '0) begin
                    state_d = CoinIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = CoinIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign coin = (state_q == CoinHold);

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and MiSTer joysticks into per-player control bytes with rotation,
// SOCD cleaning and coin stretching. Autofire is built only with ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS      = 2,
    parameter int unsigned COIN_HOLD    = 1_800_000,
    parameter int unsigned AUTOFIRE_DIV = 600_000
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic [PLAYERS*16-1:0]   joystick,
    input  logic [1:0]              rotate,
    input  logic                    socd_clean,
    input  logic [PLAYERS-1:0]      autofire,
    output logic [PLAYERS*8-1:0]    p_ctrl
);

    logic            armed_q;
    logic            toggle_q;
    logic [1:0][8:0] key_q;
    key_slot_t       slot;
    logic            unused_top;

    assign slot = sc_decode(ps2_key[7:0]);

    // The first edge out of reset only samples the toggle so a stale event is not replayed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q  <= 1'b0;
            toggle_q <= 1'b0;
            key_q    <= '0;
        end else if (!armed_q) begin
            armed_q  <= 1'b1;
            toggle_q <= ps2_key[10];
        end else if (ps2_key[10] != toggle_q) begin
            toggle_q <= ps2_key[10];
            if (slot.hit) begin
                key_q[slot.player][slot.slot] <= ps2_key[9];
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    assign unused_top = ps2_key[8];
`else
    localparam int unsigned unused_af_div = AUTOFIRE_DIV;
    assign unused_top = ^{ps2_key[8], autofire};
`endif

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [15:0] joy;
        logic [8:0]  kb;
        logic        start2;
        logic        dir_u, dir_d, dir_l, dir_r;
        logic        rot_u, rot_d, rot_l, rot_r;
        logic        fire, fire_out, coin_raw, coin_out;
        logic [7:0]  ctrl_q;
        logic        unused_joy;

        assign joy        = joystick[16*p +: 16];
        assign unused_joy = ^{joy[15:9], joy[JS_START2]};

        if (p < 2) begin : g_kb
            assign kb = key_q[p];
        end else begin : g_no_kb
            assign kb = '0;
        end

        if (p == 1) begin : g_start2
            assign start2 = joystick[JS_START2];
        end else begin : g_no_start2
            assign start2 = 1'b0;
        end

        always_comb begin
            dir_u = kb[PC_UP]    | joy[JS_UP];
            dir_d = kb[PC_DOWN]  | joy[JS_DOWN];
            dir_l = kb[PC_LEFT]  | joy[JS_LEFT];
            dir_r = kb[PC_RIGHT] | joy[JS_RIGHT];
            rot_u = dir_u;
            rot_d = dir_d;
            rot_l = dir_l;
            rot_r = dir_r;
            case (rotate_t'(rotate))
                ROT_LEFT:  begin rot_u = dir_l; rot_d = dir_r; rot_l = dir_d; rot_r = dir_u; end
                ROT_RIGHT: begin rot_u = dir_r; rot_d = dir_l; rot_l = dir_u; rot_r = dir_d; end
                ROT_180:   begin rot_u = dir_d; rot_d = dir_u; rot_l = dir_r; rot_r = dir_l; end
                default:   ;
            endcase
        end

        assign fire     = kb[PC_FIRE] | joy[JS_FIRE];
        assign coin_raw = kb[PC_COIN] | joy[JS_COIN];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        localparam int unsigned AfW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
        logic [AfW-1:0] af_cnt_q;
        logic           af_phase_q;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt_q   <= '0;
                af_phase_q <= 1'b0;
            end else if (autofire[p] && fire) begin
                if (af_cnt_q == AfW'(AUTOFIRE_DIV - 1)) begin
                    af_cnt_q   <= '0;
                    af_phase_q <= ~af_phase_q;
                end else begin
                    af_cnt_q <= af_cnt_q + AfW'(1);
                end
            end else begin
                af_cnt_q   <= '0;
                af_phase_q <= 1'b0;
            end
        end

        assign fire_out = fire & ~(autofire[p] & af_phase_q);
`else
        assign fire_out = fire;
`endif

        arcade_coin_stretch #(
            .COIN_HOLD (COIN_HOLD)
        ) u_coin (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .armed    (armed_q),
            .coin_raw (coin_raw),
            .coin     (coin_out)
        );

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q[PC_UP]    <= rot_u & ~(socd_clean & rot_d);
                ctrl_q[PC_DOWN]  <= rot_d & ~(socd_clean & rot_u);
                ctrl_q[PC_LEFT]  <= rot_l & ~(socd_clean & rot_r);
                ctrl_q[PC_RIGHT] <= rot_r & ~(socd_clean & rot_l);
                ctrl_q[PC_FIRE]  <= fire_out;
                ctrl_q[PC_BOMB]  <= kb[PC_BOMB] | joy[JS_BOMB];
                ctrl_q[PC_START] <= kb[PC_START] | kb[KS_START_ALT] | joy[JS_START] | start2;
                ctrl_q[PC_COIN]  <= coin_out;
            end
        end

        assign p_ctrl[8*p +: 8] = ctrl_q;
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with a cycle-level reference model and literal checks.
// Expects the autofire pattern matching whether ARCADE_INPUT_AUTOFIRE_EN is defined.
module tb_arcade_input_mapper;

    localparam int PL = 2;
    localparam int CH = 8;
    localparam int AD = 4;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [10:0]       ps2_key;
    logic [PL*16-1:0]  joystick;
    logic [1:0]        rotate;
    logic              socd_clean;
    logic [PL-1:0]     autofire;
    logic [PL*8-1:0]   p_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    arcade_input_mapper #(
        .PLAYERS      (PL),
        .COIN_HOLD    (CH),
        .AUTOFIRE_DIV (AD)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick   (joystick),
        .rotate     (rotate),
        .socd_clean (socd_clean),
        .autofire   (autofire),
        .p_ctrl     (p_ctrl)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: key array by scancode, time-stamped coin and autofire windows.
    bit              keys [256];
    bit              armed_m;
    bit              tog_m;
    bit              prev_coin [PL];
    int              coin_start [PL];
    int              busy_from [PL];
    int              af_start [PL];
    int              cyc;
    logic [PL*8-1:0] exp_ctrl;

    function automatic bit kb(input int p, input int f);
        bit v;
        v = 1'b0;
        if (p == 0) begin
            case (f)
                0: v = keys[8'h75];
                1: v = keys[8'h72];
                2: v = keys[8'h6B];
                3: v = keys[8'h74];
                4: v = keys[8'h29];
                5: v = keys[8'h14];
                6: v = keys[8'h16] | keys[8'h05];
                7: v = keys[8'h2E];
                default: v = 1'b0;
            endcase
        end else if (p == 1) begin
            case (f)
                0: v = keys[8'h2D];
                1: v = keys[8'h2B];
                2: v = keys[8'h23];
                3: v = keys[8'h34];
                4: v = keys[8'h1C];
                5: v = keys[8'h1B];
                6: v = keys[8'h1E] | keys[8'h06];
                7: v = keys[8'h36];
                default: v = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 256; k++) keys[k] = 1'b0;
        armed_m = 1'b0;
        tog_m   = 1'b0;
        cyc     = 0;
        for (int p = 0; p < PL; p++) begin
            prev_coin[p]  = 1'b0;
            coin_start[p] = -1;
            busy_from[p]  = 0;
            af_start[p]   = -1;
        end
        exp_ctrl = '0;
    endtask

    task automatic model_step();
        bit          din [4];
        bit          dout [4];
        bit          f, b, s, c, f_o, c_o;
        logic [15:0] j;
        int          sh;
        cyc++;
        for (int p = 0; p < PL; p++) begin
            j = joystick[16*p +: 16];
            // Directions clockwise: 0 up, 1 right, 2 down, 3 left; rotation is a quarter-turn shift.
            din[0] = kb(p, 0) | j[3];
            din[1] = kb(p, 3) | j[0];
            din[2] = kb(p, 1) | j[2];
            din[3] = kb(p, 2) | j[1];
            sh = (rotate == 2'd1) ? 3 : (rotate == 2'd2) ? 1 : (rotate == 2'd3) ? 2 : 0;
            for (int k = 0; k < 4; k++) dout[k] = din[(k + sh) % 4];
            if (socd_clean && dout[0] && dout[2]) begin dout[0] = 1'b0; dout[2] = 1'b0; end
            if (socd_clean && dout[1] && dout[3]) begin dout[1] = 1'b0; dout[3] = 1'b0; end
            f = kb(p, 4) | j[4];
            b = kb(p, 5) | j[5];
            s = kb(p, 6) | j[6] | ((p == 1) && joystick[7]);
            c = kb(p, 7) | j[8];
            f_o = f;
            if (AF_EN && autofire[p] && f) begin
                if (af_start[p] < 0) af_start[p] = cyc;
                f_o = (((cyc - af_start[p]) / AD) % 2) == 0;
            end else begin
                af_start[p] = -1;
            end
            c_o = (coin_start[p] >= 0) && (cyc > coin_start[p]) && (cyc <= coin_start[p] + CH);
            if (armed_m && c && !prev_coin[p] && cyc >= busy_from[p]) begin
                coin_start[p] = cyc;
                busy_from[p]  = cyc + 2 * CH + 1;
            end
            prev_coin[p] = c;
            exp_ctrl[8*p +: 8] = {c_o, s, b, f_o, dout[1], dout[3], dout[2], dout[0]};
        end
        if (!armed_m) begin
            armed_m = 1'b1;
            tog_m   = ps2_key[10];
        end else if (ps2_key[10] != tog_m) begin
            tog_m = ps2_key[10];
            keys[ps2_key[7:0]] = ps2_key[9];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
            #1;
            check("p_ctrl_model", p_ctrl, exp_ctrl);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_key(input logic [7:0] sc, input logic pressed, input logic ext);
        ps2_key = {~ps2_key[10], pressed, ext, sc};
    endtask

    logic [25:0] hist;
    logic [19:0] fire_hist;
    int          cnt;

    initial begin
        ps2_key    = {1'b1, 1'b1, 1'b0, 8'h29};
        joystick   = '0;
        rotate     = 2'd0;
        socd_clean = 1'b0;
        autofire   = '0;
        tick(3);
        check("reset_p_ctrl", p_ctrl, 0);
        reset_n = 1'b1;

        // Arm cycle must not turn the pending space toggle into a keypress.
        tick(3);
        check("arm_no_phantom_fire", p_ctrl[4], 0);
        send_key(8'h29, 1'b1, 1'b0);
        tick(1);
        check("kb_fire_lat1", p_ctrl[4], 0);
        tick(1);
        check("kb_fire_lat2", p_ctrl[4], 1);
        send_key(8'h29, 1'b0, 1'b0);
        tick(3);

        rotate = 2'd1; joystick[1] = 1'b1;
        tick(1);
        check("rot_left_L_up", p_ctrl[3:0], 4'b0001);
        rotate = 2'd3; joystick[1] = 1'b0; joystick[3] = 1'b1;
        tick(1);
        check("rot_180_U_down", p_ctrl[3:0], 4'b0010);
        rotate = 2'd2; joystick[3] = 1'b0; joystick[0] = 1'b1;
        tick(1);
        check("rot_right_R_up", p_ctrl[3:0], 4'b0001);
        rotate = 2'd0; joystick = '0;
        tick(2);

        socd_clean = 1'b1;
        send_key(8'h6B, 1'b1, 1'b1);
        tick(1);
        send_key(8'h74, 1'b1, 1'b1);
        tick(1);
        joystick[3] = 1'b1;
        tick(2);
        check("socd_clean_on", p_ctrl[3:0], 4'b0001);
        socd_clean = 1'b0;
        tick(1);
        check("socd_clean_off", p_ctrl[3:0], 4'b1101);
        send_key(8'h6B, 1'b0, 1'b1);
        tick(1);
        send_key(8'h74, 1'b0, 1'b1);
        joystick = '0;
        tick(3);

        send_key(8'h1C, 1'b1, 1'b0);
        joystick[7] = 1'b1;
        tick(2);
        check("p2_kb_fire", p_ctrl[12], 1);
        check("p2_start_from_js0", p_ctrl[14], 1);
        check("p1_start_clear", p_ctrl[6], 0);
        send_key(8'h1C, 1'b0, 1'b0);
        joystick = '0;
        tick(3);

        // P2 coin: 1-cycle pulses at 0, 5 (dropped) and 17 (accepted) cycles.
        for (int i = 0; i < 26; i++) begin
            joystick[24] = (i == 0) || (i == 5) || (i == 17);
            @(negedge clk_sys);
            hist[i] = p_ctrl[15];
        end
        joystick[24] = 1'b0;
        cnt = 0;
        for (int i = 0; i <= 16; i++) cnt += int'(hist[i]);
        check("coin_width", cnt, 8);
        check("coin_lat_js", {hist[1], hist[0]}, 2'b10);
        check("coin_second_edge_dropped", hist[16:9], 8'h00);
        check("coin_rearm_accept", hist[18], 1);
        tick(20);

        joystick[8] = 1'b1;
        tick(3);
        check("p1_coin_hold", p_ctrl[7], 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_clear", p_ctrl, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            cnt += int'(p_ctrl[7]);
        end
        check("held_coin_no_retrigger", cnt, 0);
        joystick[8] = 1'b0;
        tick(2);
        joystick[8] = 1'b1;
        tick(1);
        check("coin_new_edge_lat1", p_ctrl[7], 0);
        tick(1);
        check("coin_new_edge_lat2", p_ctrl[7], 1);
        joystick[8] = 1'b0;
        tick(20);

        send_key(8'h2E, 1'b1, 1'b0);
        tick(1);
        check("kb_coin_lat1", p_ctrl[7], 0);
        tick(1);
        check("kb_coin_lat2", p_ctrl[7], 0);
        tick(1);
        check("kb_coin_lat3", p_ctrl[7], 1);
        send_key(8'h2E, 1'b0, 1'b0);
        tick(20);

        autofire[0] = 1'b1;
        joystick[4] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            fire_hist[19 - i] = p_ctrl[4];
        end
        joystick[4] = 1'b0;
        check("autofire_pattern", fire_hist, AF_EN ? 20'b1111_0000_1111_0000_1111 : 20'hF_FFFF);
        tick(2);
        check("fire_release", p_ctrl[4], 0);
        autofire = '0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end between hps_io and an arcade core. Merges PS/2 keyboard events and up to four MiSTer joysticks into per-player control vectors. Applies screen-rotation remapping and SOCD cleaning, and stretches coin requests into fixed-width pulses with lockout. It replaces the per-core ad-hoc keyboard/joystick glue in emu tops.

## Interface

- PLAYERS, 2, number of player channels (1..4)
- COIN_HOLD, 1_800_000, coin output high time in clk_sys cycles (100 ms at 18 MHz); also the minimum low gap
- AUTOFIRE_DIV, 600_000, autofire half-period in clk_sys cycles
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick  in  PLAYERS*16  packed; player i at [16i+15:16i]; bits [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start [7]start-P2 (player 0 only) [8]coin
- rotate  in  2  0 none, 1 left-hand (horizontal cabinet), 2 right-hand, 3 180°
- socd_clean  in  1  1 = opposing directions resolve to neutral
- autofire  in  PLAYERS  per-player autofire enable
- p_ctrl  out  PLAYERS*8  player i at [8i+7:8i]: [0]up [1]down [2]left [3]right [4]fire [5]bomb [6]start [7]coin; active-high

## Operation

- Keyboard tracker:
  - The toggle register tracks ps2_key[10].
  - An event is processed on the first edge where the two differ; the key-state bit for the scancode is set to `pressed`.
  - Extended flag is ignored for arrows and ctrl.
  - Fixed map:
    - P1: arrows, space (fire), ctrl (bomb), 1/F1 (start), 5 (coin).
    - P2: R/F/D/G (up/down/left/right), A (fire), S (bomb), 2/F2 (start), 6 (coin).
    - Players 2/3 have no keys.
  - Unmapped scancodes are ignored.
- Source merge per player: raw = key state OR joystick. Player 1 start also ORs joystick[7] of player 0.
- Rotation applies to the merged directions:
  - rotate=1: up←L, down←R, left←D, right←U.
  - rotate=2: up←R, down←L, left←U, right←D.
  - rotate=3: up↔down, left↔right.
- SOCD (after rotation): if socd_clean, up&down → both 0, and left&right → both 0.
- Coin channel, one per player, FSM IDLE→HOLD→GAP→IDLE:
  - IDLE: a rising edge of raw coin starts HOLD, with the counter loaded to COIN_HOLD-1 and coin=1.
  - HOLD: at counter 0, go to GAP with coin=0 and the counter reloaded.
  - GAP: at counter 0, return to IDLE.
  - Edges seen in HOLD or GAP are dropped, not queued.
  - A coin still held when GAP ends does not retrigger; a new rising edge is required.
- Autofire: see Configuration.

## Timing

- Reset values:
  - p_ctrl all 0.
  - All key states 0.
  - Coin FSMs in IDLE, counters 0.
  - Coin edge registers 0.
- First edge after reset deassertion is an arm cycle: the toggle register captures ps2_key[10] and no event is processed. This prevents a phantom keypress.
- Latency:
  - Joystick/rotate/socd_clean → p_ctrl direction/fire/bomb/start: 1 cycle (registered output).
  - ps2 toggle → p_ctrl: 2 cycles.
  - Joystick coin rising edge → p_ctrl coin high: 2 cycles. Keyboard coin: 3 cycles.
- Coin high exactly COIN_HOLD cycles, then low for at least COIN_HOLD cycles.
- Simultaneous press and release of the same key in consecutive events: the last event wins.
- Keyboard and joystick are ORed, so neither source masks the other.
- rotate changes take effect on the next edge; no glitch filtering.
- Reset mid-HOLD forces coin low at once and returns the FSM to IDLE.

## Configuration

- ARCADE_INPUT_AUTOFIRE_EN defined:
  - When autofire[i] and merged fire are both 1, fire output toggles every AUTOFIRE_DIV cycles.
  - Output is high on the first press cycle.
  - The per-player counter clears on fire release.
- Undefined:
  - The autofire port is present but ignored, and fire passes straight through.
  - No counters are synthesised and AUTOFIRE_DIV is unused.

## Structure

- Package arcade_input_pkg holds:
  - p_ctrl bit index constants.
  - Joystick bit index constants.
  - rotate_t enum (ROT_NONE, ROT_LEFT, ROT_RIGHT, ROT_180).
  - Coin FSM state enum.
  - PS/2 scancode localparams.
- Sub-module arcade_coin_stretch:
  - One coin channel: edge detect, FSM and counter.
  - Parameter COIN_HOLD.
  - Generated PLAYERS times.

## Test plan

- Reset release with ps2_key[10]=1 and pressed=1 for scancode 0x29 → P1 fire stays 0; the next toggle with 0x29 pressed → fire=1 two cycles later.
- rotate=1, joystick0 bit[1] (L) held → P1 up=1, others 0. rotate=3, joystick0 bit[3] (U) → down=1.
- socd_clean=1, keyboard left+right with joystick up → p_ctrl[3:0]=4'b0001. socd_clean=0 → 4'b1101.
- COIN_HOLD=8:
  - Joystick1 coin pulse of 1 cycle → P2 coin high exactly 8 cycles.
  - A second edge 5 cycles later → ignored.
  - An edge 17 cycles after the first → accepted.
- reset_n asserted mid-HOLD → coin 0 asynchronously. After release, the same held coin yields no pulse until a new rising edge.
- With ARCADE_INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=4, fire held 20 cycles → fire pattern 1111 0000 1111 0000 1111. Without the macro → fire constant 1.
